controlador_correccion: RTL and testbench
=========================================

CONTROLADOR_CORRECCION -- requirements
Module: controlador_correccion

Interface
Parameters
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the corrected-error counter.
Ports
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port valid_in, input, 1 bit: a received word is present on datos_recibidos.
REQ-005 The block SHALL have port ready_in, output, 1 bit: the block can accept a word this cycle.
REQ-006 The block SHALL have port datos_recibidos, input, 7 bits: received codeword [i3,i2,i1,c2,i0,c1,c0]; bit k is Hamming position k+1.
REQ-007 The block SHALL have port valid_out, output, 1 bit: the result outputs are valid.
REQ-008 The block SHALL have port ready_out, input, 1 bit: the consumer accepts the result.
REQ-009 The block SHALL have port data, output, 4 bits: corrected information bits [i3,i2,i1,i0].
REQ-010 The block SHALL have port sindrome, output, 3 bits: registered syndrome [p2,p1,p0] of the accepted word.
REQ-011 The block SHALL have port error_detectado, output, 1 bit: the syndrome of the current result is non-zero.
REQ-012 The block SHALL have port limpiar_contador, input, 1 bit: synchronous clear of contador_errores.
REQ-013 The block SHALL have port contador_errores, output, CNT_W bits: saturating count of corrected words.

Function
REQ-014 The FSM SHALL have four states, IDLE, SINDROME, CORRIGE and SALIDA, with transitions as follows.
- IDLE -> SINDROME when valid_in=1.
- SINDROME -> CORRIGE unconditionally.
- CORRIGE -> SALIDA unconditionally.
- SALIDA -> IDLE when ready_out=1; otherwise the FSM stays in SALIDA.
REQ-015 ready_in SHALL be 1 only in IDLE; a word is accepted on a rising edge where valid_in=1 and ready_in=1, and datos_recibidos is captured into an internal register at that edge.
REQ-016 In SINDROME the block SHALL compute and register the syndrome from the captured word:
- p0 = c0^i0^i1^i3
- p1 = c1^i0^i2^i3
- p2 = c2^i1^i2^i3
- the syndrome value s = 4*p2 + 2*p1 + p0.
REQ-017 In CORRIGE, when s != 0 the block SHALL invert captured bit s-1; when s = 0 the word SHALL pass unchanged. The corrected word is registered.
REQ-018 valid_out SHALL be 1 only in SALIDA, first asserting in the cycle after the third rising edge following acceptance (fixed latency 3).
REQ-019 While valid_out=1 and ready_out=0, data, sindrome and error_detectado SHALL hold stable; ready_in SHALL stay 0.
REQ-020 data SHALL equal the corrected bits [6],[5],[4],[2] of the corrected word, in that order.
REQ-021 error_detectado SHALL equal OR of the registered sindrome bits.
REQ-022 contador_errores SHALL increment by 1 on the CORRIGE -> SALIDA edge when s != 0, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-023 limpiar_contador=1 SHALL set contador_errores to 0 at the next edge; if it coincides with an increment, clear SHALL win and the result SHALL be 0.
REQ-024 Double-bit errors SHALL NOT be detected distinctly; they are treated as single-bit errors per REQ-017, and this is documented behaviour.
REQ-025 Maximum throughput SHALL be one word per 4 cycles. The word following a result SHALL be acceptable in the cycle after the SALIDA -> IDLE edge.

Reset
REQ-026 rst_n=0 SHALL asynchronously force the following, regardless of the current state, including mid-operation; any in-flight word is discarded.
- state to IDLE
- ready_in=0 while rst_n=0, then 1 in IDLE
- valid_out=0
- data=0, sindrome=0, error_detectado=0
- contador_errores=0
- the internal capture and corrected-word registers to 0
REQ-027 After rst_n deasserts, the first acceptance SHALL be possible at the first rising edge with valid_in=1.

Verification
REQ-028 Clean word: datos_recibidos=7'h55 accepted, ready_out=1 -> after 3 edges valid_out=1, data=4'b1011, sindrome=3'b000, error_detectado=0, contador_errores unchanged.
REQ-029 Single error on i0: 7'h51 -> data=4'b1011, sindrome=3'b011, error_detectado=1, contador_errores incremented by 1.
REQ-030 Single error on i3: 7'h40 -> data=4'b0000, sindrome=3'b111; check errors on parity bits (7'h01 -> sindrome=3'b001, data=4'b0000).
REQ-031 Backpressure: hold ready_out=0 for 5 cycles with valid_in=1 and a new word present -> outputs stable, ready_in=0, second word accepted only after the SALIDA handshake.
REQ-032 Counter: with CNT_W=2, send 5 erroneous words -> contador_errores saturates at 3; limpiar_contador=1 on the same edge as an increment -> 0.
REQ-033 Reset mid-operation: assert rst_n=0 while in CORRIGE -> valid_out=0 and all outputs 0 immediately; after release, a clean 7'h00 -> data=4'b0000 with latency 3.

Source files
------------

// File: rtl/controlador_correccion.sv
// Hamming(7,4) single-error corrector with valid/ready handshakes and a
// saturating count of corrected words. Double errors are miscorrected as single errors.
module controlador_correccion #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [6:0]       datos_recibidos,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [3:0]       data,
  output logic [2:0]       sindrome,
  output logic             error_detectado,
  input  logic             limpiar_contador,
  output logic [CNT_W-1:0] contador_errores
);

  typedef enum logic [1:0] {IDLE, SINDROME, CORRIGE, SALIDA} estado_t;

  estado_t          estado, estado_sig;
  logic [6:0]       captura;
  logic [6:0]       corregida;
  logic [6:0]       mascara;
  logic [2:0]       sindrome_r;
  logic [2:0]       sindrome_calc;
  logic [CNT_W-1:0] contador;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= IDLE;
    else        estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      IDLE:     if (valid_in) estado_sig = SINDROME;
      SINDROME: estado_sig = CORRIGE;
      CORRIGE:  estado_sig = SALIDA;
      SALIDA:   if (ready_out) estado_sig = IDLE;
      default:  estado_sig = IDLE;
    endcase
  end

  // Bit k of the codeword is Hamming position k+1, so a non-zero syndrome names the bad bit.
  always_comb begin
    sindrome_calc[0] = captura[0] ^ captura[2] ^ captura[4] ^ captura[6];
    sindrome_calc[1] = captura[1] ^ captura[2] ^ captura[5] ^ captura[6];
    sindrome_calc[2] = captura[3] ^ captura[4] ^ captura[5] ^ captura[6];
    mascara = '0;
    if (sindrome_r != 3'd0) mascara = 7'b1 << (sindrome_r - 3'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      captura    <= '0;
      sindrome_r <= '0;
      corregida  <= '0;
    end else begin
      case (estado)
        IDLE:     if (valid_in) captura <= datos_recibidos;
        SINDROME: sindrome_r <= sindrome_calc;
        CORRIGE:  corregida <= captura ^ mascara;
        default:  ;
      endcase
    end
  end

  // Clear has priority over a coinciding increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      contador <= '0;
    else if (limpiar_contador)
      contador <= '0;
    else if (estado == CORRIGE && sindrome_r != 3'd0 && contador != {CNT_W{1'b1}})
      contador <= contador + 1'b1;
  end

  assign ready_in         = rst_n && (estado == IDLE);
  assign valid_out        = (estado == SALIDA);
  assign data             = {corregida[6], corregida[5], corregida[4], corregida[2]};
  assign sindrome         = sindrome_r;
  assign error_detectado  = |sindrome_r;
  assign contador_errores = contador;

endmodule

// File: tb/tb_controlador_correccion.sv
// Self-checking bench for controlador_correccion: two instances (CNT_W=8 and CNT_W=2)
// driven in lockstep and compared against a position-XOR Hamming model.
module tb_controlador_correccion;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_in;
  logic [6:0] datos_recibidos;
  logic       ready_out;
  logic       limpiar_contador;

  logic       ready_in, valid_out, error_detectado;
  logic [3:0] data;
  logic [2:0] sindrome;
  logic [7:0] contador_errores;

  logic       ready_in_b, valid_out_b, error_detectado_b;
  logic [3:0] data_b;
  logic [2:0] sindrome_b;
  logic [1:0] contador_errores_b;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;
  int exp_cnt2 = 0;

  always #5 clk = ~clk;

  controlador_correccion #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in),
    .datos_recibidos(datos_recibidos), .valid_out(valid_out), .ready_out(ready_out),
    .data(data), .sindrome(sindrome), .error_detectado(error_detectado),
    .limpiar_contador(limpiar_contador), .contador_errores(contador_errores)
  );

  controlador_correccion #(.CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in_b),
    .datos_recibidos(datos_recibidos), .valid_out(valid_out_b), .ready_out(ready_out),
    .data(data_b), .sindrome(sindrome_b), .error_detectado(error_detectado_b),
    .limpiar_contador(limpiar_contador), .contador_errores(contador_errores_b)
  );

  // Syndrome as the XOR of the Hamming positions of all set bits.
  function automatic logic [2:0] ref_syn(input logic [6:0] w);
    int s = 0;
    for (int k = 0; k < 7; k++) if (w[k]) s = s ^ (k + 1);
    return 3'(s);
  endfunction

  function automatic logic [3:0] ref_data(input logic [6:0] w);
    logic [6:0] c = w;
    int s = int'(ref_syn(w));
    if (s != 0) c[s-1] = ~c[s-1];
    return {c[6], c[5], c[4], c[2]};
  endfunction

  function automatic void note_word(input logic [6:0] w);
    if (ref_syn(w) != 3'd0) begin
      if (exp_cnt < 255) exp_cnt++;
      if (exp_cnt2 < 3) exp_cnt2++;
    end
  endfunction

  // Offers one word and returns edges from acceptance until valid_out (-1 if never ready).
  task automatic applyStimulus(input logic [6:0] w, output int lat);
    int waited = 0;
    lat = -1;
    while (!ready_in && waited < 10) begin
      @(posedge clk); #1; waited++;
    end
    if (!ready_in) return;
    datos_recibidos = w;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    lat = 1;
    while (!valid_out && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic finish_word();
    ready_out = 1'b1;
    @(posedge clk); #1;
    ready_out = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_in = 1'b0; ready_out = 1'b0; limpiar_contador = 1'b0;
    datos_recibidos = 7'h7f;
    #12;
    n_checks++;
    if ({ready_in, valid_out, data, sindrome, error_detectado, contador_errores} !== 17'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b d=%h s=%h e=%b c=%0d, want all 0",
               ready_in, valid_out, data, sindrome, error_detectado, contador_errores);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (ready_in !== 1'b1) begin
      n_fail++; $display("[TB] FAIL reset_release_ready: got %b want 1", ready_in);
    end
  endtask

  task automatic test_vectors();
    logic [6:0] words [4] = '{7'h55, 7'h51, 7'h40, 7'h01};
    logic [3:0] edata [4] = '{4'b1011, 4'b1011, 4'b0000, 4'b0000};
    logic [2:0] esyn  [4] = '{3'b000, 3'b011, 3'b111, 3'b001};
    int lat;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(words[i], lat);
      note_word(words[i]);
      n_checks++;
      if (lat !== 3) begin
        n_fail++; $display("[TB] FAIL vec%0d_latency: got %0d want 3", i, lat);
      end
      n_checks++;
      if ({data, sindrome, error_detectado} !== {edata[i], esyn[i], esyn[i] != 3'd0}) begin
        n_fail++;
        $display("[TB] FAIL vec%0d_result: got d=%b s=%b e=%b want d=%b s=%b e=%b", i,
                 data, sindrome, error_detectado, edata[i], esyn[i], esyn[i] != 3'd0);
      end
      n_checks++;
      if (contador_errores !== 8'(exp_cnt)) begin
        n_fail++; $display("[TB] FAIL vec%0d_count: got %0d want %0d", i, contador_errores, exp_cnt);
      end
      finish_word();
      n_checks++;
      if ({valid_out, ready_in} !== 2'b01) begin
        n_fail++; $display("[TB] FAIL vec%0d_return_idle: got vld=%b rdy=%b want 0 1", i, valid_out, ready_in);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] w;
    int lat;
    for (int i = 0; i < 24; i++) begin
      w = 7'($urandom_range(0, 127));
      applyStimulus(w, lat);
      note_word(w);
      n_checks++;
      if (lat !== 3 || data !== ref_data(w) || sindrome !== ref_syn(w) ||
          error_detectado !== (ref_syn(w) != 3'd0)) begin
        n_fail++;
        $display("[TB] FAIL rand%0d w=%h: got lat=%0d d=%b s=%b e=%b want lat=3 d=%b s=%b e=%b",
                 i, w, lat, data, sindrome, error_detectado, ref_data(w), ref_syn(w), ref_syn(w) != 3'd0);
      end
      n_checks++;
      if (contador_errores !== 8'(exp_cnt) || contador_errores_b !== 2'(exp_cnt2)) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_count: got %0d/%0d want %0d/%0d", i,
                 contador_errores, contador_errores_b, exp_cnt, exp_cnt2);
      end
      finish_word();
    end
  endtask

  task automatic test_backpressure();
    logic [6:0] w1 = 7'h23;
    logic [6:0] w2 = 7'h6a;
    int lat;
    applyStimulus(w1, lat);
    note_word(w1);
    datos_recibidos = w2;
    valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({valid_out, ready_in} !== 2'b10 || data !== ref_data(w1) || sindrome !== ref_syn(w1) ||
          error_detectado !== (ref_syn(w1) != 3'd0)) begin
        n_fail++;
        $display("[TB] FAIL bp_hold%0d: got vld=%b rdy=%b d=%b s=%b want vld=1 rdy=0 d=%b s=%b",
                 i, valid_out, ready_in, data, sindrome, ref_data(w1), ref_syn(w1));
      end
    end
    finish_word();
    n_checks++;
    if ({valid_out, ready_in} !== 2'b01) begin
      n_fail++; $display("[TB] FAIL bp_idle: got vld=%b rdy=%b want 0 1", valid_out, ready_in);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    note_word(w2);
    lat = 1;
    while (!valid_out && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    n_checks++;
    if (lat !== 3 || data !== ref_data(w2) || sindrome !== ref_syn(w2)) begin
      n_fail++;
      $display("[TB] FAIL bp_second: got lat=%0d d=%b s=%b want lat=3 d=%b s=%b",
               lat, data, sindrome, ref_data(w2), ref_syn(w2));
    end
    finish_word();
  endtask

  task automatic test_counter();
    logic [6:0] w;
    int lat;
    limpiar_contador = 1'b1;
    @(posedge clk); #1;
    limpiar_contador = 1'b0;
    exp_cnt = 0; exp_cnt2 = 0;
    n_checks++;
    if (contador_errores !== 8'd0 || contador_errores_b !== 2'd0) begin
      n_fail++; $display("[TB] FAIL cnt_clear: got %0d/%0d want 0/0", contador_errores, contador_errores_b);
    end
    for (int i = 0; i < 5; i++) begin
      w = 7'($urandom_range(0, 127));
      if (ref_syn(w) == 3'd0) w[0] = ~w[0];
      applyStimulus(w, lat);
      note_word(w);
      n_checks++;
      if (contador_errores !== 8'(exp_cnt) || contador_errores_b !== 2'(exp_cnt2)) begin
        n_fail++;
        $display("[TB] FAIL cnt_sat%0d: got %0d/%0d want %0d/%0d", i,
                 contador_errores, contador_errores_b, exp_cnt, exp_cnt2);
      end
      finish_word();
    end
    n_checks++;
    if (contador_errores_b !== 2'd3) begin
      n_fail++; $display("[TB] FAIL cnt_saturated: got %0d want 3", contador_errores_b);
    end
    // Clear lands on the same edge that would count this erroneous word.
    datos_recibidos = 7'h40;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    limpiar_contador = 1'b1;
    @(posedge clk); #1;
    limpiar_contador = 1'b0;
    exp_cnt = 0; exp_cnt2 = 0;
    n_checks++;
    if (valid_out !== 1'b1 || contador_errores !== 8'd0 || contador_errores_b !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL cnt_clear_wins: got vld=%b cnt=%0d/%0d want 1 0/0",
               valid_out, contador_errores, contador_errores_b);
    end
    finish_word();
  endtask

  task automatic test_reset_mid();
    int lat;
    datos_recibidos = 7'h51;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0; exp_cnt2 = 0;
    n_checks++;
    if ({ready_in, valid_out, data, sindrome, error_detectado, contador_errores, contador_errores_b} !== 19'd0) begin
      n_fail++;
      $display("[TB] FAIL midreset_outputs: got rdy=%b vld=%b d=%h s=%h e=%b c=%0d want all 0",
               ready_in, valid_out, data, sindrome, error_detectado, contador_errores);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    applyStimulus(7'h00, lat);
    n_checks++;
    if (lat !== 3 || data !== 4'b0000 || sindrome !== 3'b000 || contador_errores !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL midreset_after: got lat=%0d d=%b s=%b c=%0d want lat=3 d=0000 s=000 c=0",
               lat, data, sindrome, contador_errores);
    end
    finish_word();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_backpressure();
    test_counter();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
